wb_cmd_master: RTL and testbench
================================

# wb_cmd_master

Wishbone classic-cycle initiator that turns single commands from a valid/ready command port into one bus transaction each and returns the read data and completion status on a valid/ready response port. It is the initiator end of the user-area Wishbone fabric. It drives the same address-decoded bus splitter and peripherals (PWM timers at 0x3000_0000–0x3000_3FFF) that the management SoC drives. The command port is driven from a local sequencer or the logic analyzer.

## Interface
- BITS, 32: address and data width.
- TIMEOUT, 255: maximum cycles to wait for ack/err before forcing termination; must be ≥2.
- wb_clk_i  input  1  the single clock; all state changes on its rising edge.
- wb_rst_ni  input  1  asynchronous active-low reset.
- cmd_valid_i  input  1  command present.
- cmd_ready_o  output  1  command accepted when high with cmd_valid_i.
- cmd_adr_i  input  BITS  byte address.
- cmd_dat_i  input  BITS  write data.
- cmd_we_i  input  1  1 = write, 0 = read.
- cmd_sel_i  input  4  byte lanes.
- resp_valid_o  output  1  response present.
- resp_ready_i  input  1  response consumed when high with resp_valid_o.
- resp_dat_o  output  BITS  read data (0 for writes and failed cycles).
- resp_status_o  output  2  00 ok, 01 bus error, 10 timeout, 11 misaligned.
- wbm_cyc_o, wbm_stb_o, wbm_we_o  output  1 each  Wishbone controls.
- wbm_adr_o, wbm_dat_o  output  BITS  address / write data.
- wbm_sel_o  output  4  byte lanes.
- wbm_dat_i  input  BITS  read data.
- wbm_ack_i, wbm_err_i  input  1 each  termination.
- busy_o  output  1  high in any state other than IDLE.

## Operation
- States: IDLE, BUS, RESP. cmd_ready_o = (state==IDLE).
- IDLE, accept with cmd_adr_i[1:0]==0:
  - Register adr/dat/we/sel onto the wbm_* outputs.
  - Assert cyc/stb; go to BUS; clear the wait counter.
- IDLE, accept with cmd_adr_i[1:0]!=0:
  - No bus cycle is issued.
  - Load resp_status=11 and resp_dat=0; go to RESP.
- BUS: cyc/stb are held and wbm_adr/dat/we/sel stay stable until termination.
- Termination sampled in BUS (priority err > ack > timeout):
  - wbm_err_i: status 01, resp_dat=0.
  - wbm_ack_i: status 00; resp_dat = wbm_dat_i if read, else 0.
  - Timeout (wait counter == TIMEOUT-1, no ack/err): status 10, resp_dat=0.
  - On any termination: deassert cyc/stb and go to RESP.
- RESP: resp_valid_o=1, with resp_dat_o/resp_status_o stable. Return to IDLE on resp_ready_i.
- Wait counter: width $clog2(TIMEOUT); increments each BUS cycle without termination; saturates; never wraps.
- Ack/err arriving outside BUS are ignored.

## Timing
- Reset (async assert, sync deassert expected upstream): state IDLE. All outputs 0 except cmd_ready_o=1.
  - Reset mid-cycle drops cyc/stb immediately and discards the pending response.
- Command accepted at edge N: cyc/stb high from N to the terminating edge.
- Zero-wait slave (ack sampled at N+1): cyc/stb low after N+1; resp_valid_o high after N+1.
- Minimum command-to-command spacing is 3 cycles: accept, ack, response handshake. cmd_ready_o rises the cycle after the response handshake.
- Misaligned command: resp_valid_o high the cycle after acceptance.
- Timeout: with no termination, cyc/stb drop at the TIMEOUT-th edge after acceptance.

## Configuration
- WB_CMD_MASTER_TIMEOUT_EN defined: the wait counter and status 10 exist as described.
- Not defined: no counter; BUS waits indefinitely for ack/err; status 10 is never produced; the TIMEOUT parameter is ignored.

## Test plan
- Write 0x3000_1004 = 0xDEAD_BEEF, sel=F; slave acks in 1 cycle -> wbm_adr/dat/sel stable while cyc=1; resp status 00, dat 0.
- Read 0x3000_0008; slave acks after 3 waits with 0x1234_5678 -> resp_dat 0x1234_5678, status 00; cyc high exactly 4 cycles.
- Slave asserts err and ack together -> status 01, resp_dat 0.
- TIMEOUT=8 (macro on), silent slave -> cyc drops after 8 cycles, status 10. Macro off -> cyc stays high for 100 cycles, then ack completes with status 00.
- Command at 0x3000_0002 -> cyc never asserts; status 11 the next cycle.
- Hold resp_ready_i low 5 cycles -> cmd_ready_o stays 0 and resp stays stable. Assert wb_rst_ni low during BUS -> cyc/stb/resp_valid go 0 asynchronously.

Source files
------------

// File: rtl/wb_cmd_master.sv
// rtl/wb_cmd_master.sv - Wishbone classic-cycle initiator fed by a valid/ready command port; optional timeout via WB_CMD_MASTER_TIMEOUT_EN
module wb_cmd_master #(
    parameter int BITS    = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_ni,
    input  logic            cmd_valid_i,
    output logic            cmd_ready_o,
    input  logic [BITS-1:0] cmd_adr_i,
    input  logic [BITS-1:0] cmd_dat_i,
    input  logic            cmd_we_i,
    input  logic [3:0]      cmd_sel_i,
    output logic            resp_valid_o,
    input  logic            resp_ready_i,
    output logic [BITS-1:0] resp_dat_o,
    output logic [1:0]      resp_status_o,
    output logic            wbm_cyc_o,
    output logic            wbm_stb_o,
    output logic            wbm_we_o,
    output logic [BITS-1:0] wbm_adr_o,
    output logic [BITS-1:0] wbm_dat_o,
    output logic [3:0]      wbm_sel_o,
    input  logic [BITS-1:0] wbm_dat_i,
    input  logic            wbm_ack_i,
    input  logic            wbm_err_i,
    output logic            busy_o
);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    state_t state;
    state_t state_nxt;
    logic   accept;
    logic   misaligned;
    logic   term_to;
    logic   term;

    // A TIMEOUT below 2 leaves no room for even a zero-wait slave.
    if (TIMEOUT < 2) begin : g_timeout_check
        $error("wb_cmd_master: TIMEOUT must be >= 2");
    end

    assign accept     = cmd_valid_i && (state == IDLE);
    assign misaligned = (cmd_adr_i[1:0] != 2'b00);
    assign term       = (state == BUS) && (wbm_err_i || wbm_ack_i || term_to);

`ifdef WB_CMD_MASTER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT);

    logic [CW-1:0] wait_cnt;

    // Count bus cycles spent waiting; cleared on every accepted command, saturating.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wait_cnt <= '0;
        end else if (accept) begin
            wait_cnt <= '0;
        end else if ((state == BUS) && !term && (wait_cnt != '1)) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign term_to = (wait_cnt == CW'(TIMEOUT - 1));
`else
    assign term_to = 1'b0;
`endif

    // State register; reset drops an in-flight cycle and any pending response.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and the state-derived handshake/bus controls.
    always_comb begin
        state_nxt    = state;
        cmd_ready_o  = 1'b0;
        resp_valid_o = 1'b0;
        wbm_cyc_o    = 1'b0;
        wbm_stb_o    = 1'b0;
        busy_o       = 1'b1;
        case (state)
            IDLE: begin
                cmd_ready_o = 1'b1;
                busy_o      = 1'b0;
                if (cmd_valid_i) begin
                    state_nxt = misaligned ? RESP : BUS;
                end
            end
            BUS: begin
                wbm_cyc_o = 1'b1;
                wbm_stb_o = 1'b1;
                if (term) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                resp_valid_o = 1'b1;
                if (resp_ready_i) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Capture the command onto the bus and the termination into the response.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wbm_adr_o     <= '0;
            wbm_dat_o     <= '0;
            wbm_we_o      <= 1'b0;
            wbm_sel_o     <= 4'h0;
            resp_dat_o    <= '0;
            resp_status_o <= 2'b00;
        end else begin
            if (accept && !misaligned) begin
                wbm_adr_o <= cmd_adr_i;
                wbm_dat_o <= cmd_dat_i;
                wbm_we_o  <= cmd_we_i;
                wbm_sel_o <= cmd_sel_i;
            end
            if (accept && misaligned) begin
                resp_status_o <= 2'b11;
                resp_dat_o    <= '0;
            end else if (term) begin
                resp_dat_o    <= (wbm_ack_i && !wbm_err_i && !wbm_we_o) ? wbm_dat_i : '0;
                resp_status_o <= wbm_err_i ? 2'b01 : (wbm_ack_i ? 2'b00 : 2'b10);
            end
        end
    end

endmodule

// File: tb/tb_wb_cmd_master.sv
// tb/tb_wb_cmd_master.sv - scoreboard bench for wb_cmd_master with random commands and a behavioural slave
module tb_wb_cmd_master;
    localparam int BITS = 32;
    localparam int TO   = 8;

    logic            clk;
    logic            rst_n;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [BITS-1:0] cmd_adr;
    logic [BITS-1:0] cmd_dat;
    logic            cmd_we;
    logic [3:0]      cmd_sel;
    logic            resp_valid;
    logic            resp_ready;
    logic [BITS-1:0] resp_dat;
    logic [1:0]      resp_status;
    logic            cyc, stb, we;
    logic [BITS-1:0] adr, wdat, rdat;
    logic [3:0]      sel;
    logic            ack, err;
    logic            busy;

    wb_cmd_master #(.BITS(BITS), .TIMEOUT(TO)) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat), .cmd_we_i(cmd_we), .cmd_sel_i(cmd_sel),
        .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
        .resp_dat_o(resp_dat), .resp_status_o(resp_status),
        .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we),
        .wbm_adr_o(adr), .wbm_dat_o(wdat), .wbm_sel_o(sel),
        .wbm_dat_i(rdat), .wbm_ack_i(ack), .wbm_err_i(err),
        .busy_o(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // kind: 0 ack, 1 err, 2 err+ack together, 3 silent slave
    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        logic        we;
        logic [3:0]  sel;
        int          kind;
        int          waits;
        logic [31:0] rdata;
    } cmd_t;

    typedef struct packed {
        logic [31:0] dat;
        logic [1:0]  status;
    } resp_t;

    resp_t resp_q[$];
    cmd_t  bus_q[$];
    cmd_t  slave_q[$];
    int    len_q[$];

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc_len = 0;
    int slv_cnt = 0;
    int hold    = 0;
    bit hs_prev = 0;
    bit timeout_en;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: outcome from the command class and how the slave will behave.
    function automatic bit times_out(cmd_t c);
        return timeout_en && (c.kind == 3 || c.waits + 1 > TO);
    endfunction

    function automatic resp_t model(cmd_t c);
        resp_t r;
        r.dat = 32'h0;
        if (c.adr[1:0] != 2'b00)           r.status = 2'b11;
        else if (times_out(c))             r.status = 2'b10;
        else if (c.kind == 1 || c.kind == 2) r.status = 2'b01;
        else begin
            r.status = 2'b00;
            r.dat    = c.we ? 32'h0 : c.rdata;
        end
        return r;
    endfunction

    function automatic int bus_len(cmd_t c);
        return times_out(c) ? TO : c.waits + 1;
    endfunction

    function automatic cmd_t mk(logic [31:0] a, logic [31:0] d, logic w, logic [3:0] s,
                                int k, int n, logic [31:0] rd);
        cmd_t c;
        c.adr = a; c.dat = d; c.we = w; c.sel = s; c.kind = k; c.waits = n; c.rdata = rd;
        return c;
    endfunction

    task automatic issue(input cmd_t c);
        int guard = 0;
        @(negedge clk);
        while (!cmd_ready && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        if (!cmd_ready) begin
            check("cmd_ready_wait", 64'd0, 64'd1);
            return;
        end
        cmd_valid = 1'b1;
        cmd_adr   = c.adr;
        cmd_dat   = c.dat;
        cmd_we    = c.we;
        cmd_sel   = c.sel;
        resp_q.push_back(model(c));
        if (c.adr[1:0] == 2'b00) begin
            bus_q.push_back(c);
            slave_q.push_back(c);
            len_q.push_back(bus_len(c));
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_adr   = $urandom;
        cmd_dat   = $urandom;
        cmd_we    = 1'($urandom);
        cmd_sel   = 4'($urandom);
        if (c.adr[1:0] != 2'b00)
            check("misaligned_after_accept {cyc,resp_valid}", {62'd0, cyc, resp_valid}, 64'b01);
        else
            check("aligned_after_accept {cyc,stb,resp_valid}", {61'd0, cyc, stb, resp_valid}, 64'b110);
    endtask

    task automatic drain();
        int guard = 0;
        while ((resp_q.size() != 0 || busy) && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        check("drain_done", {63'd0, resp_q.size() == 0 && !busy}, 64'd1);
    endtask

    // Slave: ack/err on the (waits+1)-th cycle of the bus cycle; stray ack/err while idle.
    always @(negedge clk) begin
        if (!rst_n) begin
            ack = 1'b0; err = 1'b0; slv_cnt = 0;
        end else if (cyc && stb && slave_q.size() != 0) begin
            bit hit;
            cmd_t c;
            c = slave_q[0];
            slv_cnt++;
            hit  = (c.kind != 3) && (slv_cnt == c.waits + 1);
            ack  = hit && (c.kind == 0 || c.kind == 2);
            err  = hit && (c.kind == 1 || c.kind == 2);
            rdat = hit ? c.rdata : $urandom;
        end else begin
            if (slv_cnt != 0) begin
                void'(slave_q.pop_front());
                slv_cnt = 0;
            end
            ack  = ($urandom % 4 == 0);
            err  = ($urandom % 6 == 0);
            rdat = $urandom;
        end
    end

    // Bus monitor: stable controls while cyc is high, cycle length when it drops.
    always @(negedge clk) begin
        if (rst_n) begin
            if (cyc) begin
                cyc_len++;
                if (bus_q.size() != 0) begin
                    check("bus_adr", {32'd0, adr}, {32'd0, bus_q[0].adr});
                    check("bus_dat_we_sel_stb_busy", {24'd0, wdat, we, sel, stb, busy},
                          {24'd0, bus_q[0].dat, bus_q[0].we, bus_q[0].sel, 1'b1, 1'b1});
                end else begin
                    check("bus_unexpected_cyc", 64'd1, 64'd0);
                end
            end else if (cyc_len != 0) begin
                if (len_q.size() != 0) begin
                    check("cyc_len", 64'(cyc_len), 64'(len_q[0]));
                    void'(len_q.pop_front());
                    void'(bus_q.pop_front());
                end
                cyc_len = 0;
            end
        end
    end

    // Response monitor and resp_ready driver: compares every presented cycle, pops on handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            resp_ready = 1'b0;
            hs_prev    = 1'b0;
        end else begin
            if (hs_prev)
                check("cmd_ready_after_handshake", {63'd0, cmd_ready}, 64'd1);
            hs_prev = 1'b0;
            if (resp_valid) begin
                check("cmd_ready_during_resp", {63'd0, cmd_ready}, 64'd0);
                if (resp_q.size() == 0) begin
                    check("resp_unexpected", 64'd1, 64'd0);
                end else begin
                    check("resp_dat", {32'd0, resp_dat}, {32'd0, resp_q[0].dat});
                    check("resp_status", {62'd0, resp_status}, {62'd0, resp_q[0].status});
                end
                if (hold > 0) begin
                    resp_ready = 1'b0;
                    hold--;
                end else begin
                    resp_ready = ($urandom % 3 != 0);
                end
                if (resp_ready && resp_q.size() != 0) begin
                    void'(resp_q.pop_front());
                    hs_prev = 1'b1;
                end
            end else begin
                resp_ready = 1'($urandom);
            end
        end
    end

    task automatic check_idle_outputs(input string name);
        check({name, " ctrl {cmd_ready,resp_valid,cyc,stb,we,busy}"},
              {58'd0, cmd_ready, resp_valid, cyc, stb, we, busy}, 64'b100000);
        check({name, " adr/dat"}, {adr, wdat}, 64'd0);
        check({name, " sel/resp"}, {26'd0, sel, resp_dat, resp_status}, 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef WB_CMD_MASTER_TIMEOUT_EN
        timeout_en = 1'b1;
`else
        timeout_en = 1'b0;
`endif
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_adr = '0; cmd_dat = '0; cmd_we = 1'b0; cmd_sel = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        issue(mk(32'h3000_1004, 32'hDEAD_BEEF, 1'b1, 4'hF, 0, 0, 32'h5555_AAAA));
        issue(mk(32'h3000_0008, 32'h0, 1'b0, 4'hF, 0, 3, 32'h1234_5678));
        issue(mk(32'h3000_000C, 32'h0, 1'b0, 4'h3, 2, 1, 32'hCAFE_F00D));
        issue(mk(32'h3000_0010, 32'h0, 1'b0, 4'hF, 0, TO - 1, 32'h0BAD_CAFE));
        if (timeout_en)
            issue(mk(32'h3000_0014, 32'h0, 1'b0, 4'hF, 3, 0, 32'h0));
        else
            issue(mk(32'h3000_0014, 32'h0, 1'b0, 4'hF, 0, 100, 32'h7777_1111));
        issue(mk(32'h3000_0002, 32'h1, 1'b1, 4'hF, 0, 0, 32'h0));
        drain();
        hold = 5;
        issue(mk(32'h3000_2000, 32'h0, 1'b0, 4'hC, 0, 0, 32'hA5A5_5A5A));
        drain();

        for (int i = 0; i < 60; i++) begin
            cmd_t c;
            c.adr = 32'h3000_0000 | ($urandom & 32'h0000_3FFF);
            if ($urandom % 6 != 0) c.adr[1:0] = 2'b00;
            c.dat   = $urandom;
            c.we    = 1'($urandom);
            c.sel   = 4'($urandom);
            c.kind  = timeout_en ? int'($urandom % 4) : int'($urandom % 3);
            c.waits = int'($urandom % 10);
            c.rdata = $urandom;
            issue(c);
        end
        drain();

        issue(mk(32'h3000_3000, 32'h0, 1'b0, 4'hF, 0, 50, 32'h1));
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("mid_bus_reset");
        resp_q.delete(); bus_q.delete(); slave_q.delete(); len_q.delete();
        cyc_len = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        issue(mk(32'h3000_3FFC, 32'h0, 1'b0, 4'hF, 0, 2, 32'hFEED_0001));
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
